// File: rtl/sja_host_bus_slave.sv
// SJA1000-style multiplexed host bus responder with a 2**ADDR_W byte register file (MOD/CMR/IR/IER).
// Latency: pin event to register/AD_OE effect is 3 CLK; no backpressure. SJA_MOTOROLA_EN adds E/R/W decoding.
module sja_host_bus_slave #(
    parameter int          ADDR_W  = 5,
    parameter logic [7:0]  MOD_RST = 8'h01
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] AD_I,
    output logic [7:0] AD_O,
    output logic       AD_OE,
    input  logic       CS,
    input  logic       RD,
    input  logic       WR,
    input  logic       ALE,
    input  logic       MODE,
    output logic       INT,
    input  logic [7:0] irq_set,
    output logic       cmd_valid,
    output logic [7:0] cmd_data,
    output logic [7:0] mod_q
);
    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] A_MOD = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_CMR = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_IR  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_IER = ADDR_W'(4);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        regs [NREG];
    logic [7:0]        ir;
    logic [7:0]        rdata;

    logic       cs_s1, cs_s2, rd_s1, rd_s2, rd_s3, wr_s1, wr_s2, wr_s3, ale_s1, ale_s2, ale_s3;
    logic [7:0] ad_s1, ad_s2;
    logic       intel, rd_act, wr_act, commit, ir_clr;

    // Synchronisers reset to the idle Intel bus levels so no edge is seen out of reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cs_s1  <= 1'b1; cs_s2  <= 1'b1;
            rd_s1  <= 1'b1; rd_s2  <= 1'b1; rd_s3 <= 1'b1;
            wr_s1  <= 1'b1; wr_s2  <= 1'b1; wr_s3 <= 1'b1;
            ale_s1 <= 1'b0; ale_s2 <= 1'b0; ale_s3 <= 1'b0;
            ad_s1  <= 8'h00; ad_s2 <= 8'h00;
        end else begin
            cs_s1  <= CS;   cs_s2  <= cs_s1;
            rd_s1  <= RD;   rd_s2  <= rd_s1;  rd_s3 <= rd_s2;
            wr_s1  <= WR;   wr_s2  <= wr_s1;  wr_s3 <= wr_s2;
            ale_s1 <= ALE;  ale_s2 <= ale_s1; ale_s3 <= ale_s2;
            ad_s1  <= AD_I; ad_s2  <= ad_s1;
        end
    end

`ifdef SJA_MOTOROLA_EN
    logic mode_s1, mode_s2;
    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_s1 <= 1'b1; mode_s2 <= 1'b1;
        end else begin
            mode_s1 <= MODE; mode_s2 <= mode_s1;
        end
    end
    assign intel  = mode_s2;
    // Motorola: RD carries E, WR carries R/W (1 = read); commit on E falling.
    assign rd_act = intel ? ~rd_s2 : (rd_s2 & wr_s2);
    assign wr_act = intel ? ~wr_s2 : (rd_s2 & ~wr_s2);
    assign commit = intel ? (wr_s2 & ~wr_s3) : (~rd_s2 & rd_s3);
`else
    logic unused_mode;
    assign unused_mode = MODE;
    assign intel  = 1'b1;
    assign rd_act = ~rd_s2;
    assign wr_act = ~wr_s2;
    assign commit = wr_s2 & ~wr_s3;
`endif

    assign ir_clr = (state == READ) && (cs_s2 || !rd_act) && (addr_q == A_IR);
    assign mod_q  = regs[A_MOD];

    always_comb begin
        rdata = regs[addr_q];
        if (addr_q == A_CMR)
            rdata = 8'hFF;
        else if (addr_q == A_IR)
            rdata = ir;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            addr_q    <= '0;
            AD_O      <= 8'h00;
            AD_OE     <= 1'b0;
            INT       <= 1'b1;
            ir        <= 8'h00;
            cmd_valid <= 1'b0;
            cmd_data  <= 8'h00;
            for (int i = 0; i < NREG; i++)
                regs[i] <= (i == 0) ? MOD_RST : 8'h00;
        end else begin
            cmd_valid <= 1'b0;
            if (ale_s3 && !ale_s2)
                addr_q <= ad_s2[ADDR_W-1:0];
            // A set pulse landing on the clear cycle survives.
            ir  <= (ir & ~{8{ir_clr}}) | irq_set;
            INT <= ~|(ir & regs[A_IER]);
            case (state)
                IDLE: begin
                    if (!cs_s2 && rd_act) begin
                        state <= READ;
                        AD_OE <= 1'b1;
                        AD_O  <= rdata;
                    end else if (!cs_s2 && wr_act) begin
                        state <= WRITE;
                    end
                end
                READ: begin
                    if (cs_s2 || !rd_act) begin
                        state <= IDLE;
                        AD_OE <= 1'b0;
                    end else begin
                        AD_O <= rdata;
                    end
                end
                WRITE: begin
                    if (cs_s2 || rd_act) begin
                        state <= IDLE;
                    end else if (commit) begin
                        state <= IDLE;
                        if (addr_q == A_CMR) begin
                            cmd_valid <= 1'b1;
                            cmd_data  <= ad_s2;
                        end else if (addr_q != A_IR) begin
                            regs[addr_q] <= ad_s2;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sja_host_bus_slave.sv
// Directed bench for sja_host_bus_slave: a pin-level host agent drives bus cycles, read data is scoreboarded.
module tb_sja_host_bus_slave;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] AD_I = 8'h00;
    logic [7:0] AD_O;
    logic       AD_OE;
    logic       CS = 1'b1, RD = 1'b1, WR = 1'b1, ALE = 1'b0, MODE = 1'b1;
    logic       INT;
    logic [7:0] irq_set = 8'h00;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic [7:0] mod_q;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cv_cnt = 0;
    logic       moto = 1'b0;
    logic [7:0] exp_q [$];

    sja_host_bus_slave dut (
        .CLK(CLK), .RST(RST), .AD_I(AD_I), .AD_O(AD_O), .AD_OE(AD_OE),
        .CS(CS), .RD(RD), .WR(WR), .ALE(ALE), .MODE(MODE), .INT(INT),
        .irq_set(irq_set), .cmd_valid(cmd_valid), .cmd_data(cmd_data), .mod_q(mod_q)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (cmd_valid) cv_cnt <= cv_cnt + 1;

    task automatic nclk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic addr_phase(input logic [7:0] a);
        ALE = 1'b1; AD_I = a; nclk(3);
        ALE = 1'b0; nclk(4);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d, output logic cv3);
        addr_phase(a);
        CS = 1'b0; AD_I = d;
        if (moto) WR = 1'b0;
        nclk(2);
        if (moto) RD = 1'b1; else WR = 1'b0;
        nclk(4);
        if (moto) RD = 1'b0; else WR = 1'b1;
        nclk(3); cv3 = cmd_valid;
        nclk(2); CS = 1'b1;
        if (moto) WR = 1'b1;
        nclk(3);
    endtask

    task automatic bus_read(input logic [7:0] a, input logic [7:0] exp, input string tag,
                            input logic [7:0] pulse);
        logic [7:0] e;
        addr_phase(a);
        CS = 1'b0;
        if (moto) WR = 1'b1;
        nclk(2);
        exp_q.push_back(exp);
        if (moto) RD = 1'b1; else RD = 1'b0;
        nclk(2); check({tag, "_oe_early"}, 32'(AD_OE), 32'd0);
        nclk(1); check({tag, "_oe_on"}, 32'(AD_OE), 32'd1);
        e = exp_q.pop_front();
        check({tag, "_data"}, 32'(AD_O), 32'(e));
        nclk(2);
        if (moto) RD = 1'b0; else RD = 1'b1;
        nclk(2); check({tag, "_oe_held"}, 32'(AD_OE), 32'd1);
        irq_set = pulse;
        nclk(1); irq_set = 8'h00;
        check({tag, "_oe_off"}, 32'(AD_OE), 32'd0);
        CS = 1'b1;
        nclk(3);
    endtask

    initial begin
        logic cv;
        int   cv_before;

        nclk(3);
        check("rst_oe", 32'(AD_OE), 32'd0);
        check("rst_ado", 32'(AD_O), 32'h00);
        check("rst_int", 32'(INT), 32'd1);
        check("rst_cmdv", 32'(cmd_valid), 32'd0);
        check("rst_cmdd", 32'(cmd_data), 32'h00);
        check("rst_mod", 32'(mod_q), 32'h01);
        RST = 1'b0;
        nclk(3);

        bus_read(8'h00, 8'h01, "rd_mod", 8'h00);
        bus_read(8'h04, 8'h00, "rd_ier", 8'h00);
        check("int_idle", 32'(INT), 32'd1);

        bus_write(8'h07, 8'hA5, cv);
        bus_read(8'h07, 8'hA5, "rd_a7", 8'h00);
        bus_write(8'h27, 8'h5A, cv);
        bus_read(8'h07, 8'h5A, "rd_alias", 8'h00);

        cv_before = cv_cnt;
        bus_write(8'h01, 8'h0C, cv);
        check("cmd_pulse_edge", 32'(cv), 32'd1);
        check("cmd_pulse_cnt", 32'(cv_cnt - cv_before), 32'd1);
        check("cmd_data", 32'(cmd_data), 32'h0C);
        bus_read(8'h01, 8'hFF, "rd_cmr", 8'h00);

        bus_write(8'h04, 8'h01, cv);
        irq_set = 8'h01; nclk(1); irq_set = 8'h00;
        check("int_one_clk", 32'(INT), 32'd1);
        nclk(1);
        check("int_two_clk", 32'(INT), 32'd0);
        bus_read(8'h03, 8'h01, "rd_ir", 8'h00);
        check("int_after_clr", 32'(INT), 32'd1);
        bus_read(8'h03, 8'h00, "rd_ir_clr", 8'h00);

        irq_set = 8'h01; nclk(1); irq_set = 8'h00; nclk(1);
        check("int_set_again", 32'(INT), 32'd0);
        bus_read(8'h03, 8'h01, "rd_ir_race", 8'h01);
        check("int_set_wins", 32'(INT), 32'd0);
        bus_read(8'h03, 8'h01, "rd_ir_kept", 8'h00);
        check("int_final_clr", 32'(INT), 32'd1);

        bus_write(8'h05, 8'h33, cv);
        addr_phase(8'h05);
        CS = 1'b0; AD_I = 8'h77; nclk(2);
        WR = 1'b0; nclk(4);
        CS = 1'b1; nclk(4);
        WR = 1'b1; nclk(4);
        bus_read(8'h05, 8'h33, "rd_abort", 8'h00);
        check("cmd_data_held", 32'(cmd_data), 32'h0C);

        bus_write(8'h00, 8'h5E, cv);
        check("mod_write", 32'(mod_q), 32'h5E);

        addr_phase(8'h00);
        CS = 1'b0; nclk(2);
        RD = 1'b0; nclk(3);
        check("mid_rd_oe", 32'(AD_OE), 32'd1);
        RST = 1'b1; nclk(1);
        check("mid_rst_oe", 32'(AD_OE), 32'd0);
        CS = 1'b1; RD = 1'b1; nclk(3);
        RST = 1'b0; nclk(3);
        check("mid_rst_mod", 32'(mod_q), 32'h01);
        check("mid_rst_cmdd", 32'(cmd_data), 32'h00);
        check("mid_rst_int", 32'(INT), 32'd1);
        bus_read(8'h07, 8'h00, "rd_a7_rst", 8'h00);

`ifdef SJA_MOTOROLA_EN
        RD = 1'b0; nclk(1);
        MODE = 1'b0; moto = 1'b1; nclk(4);
        bus_write(8'h09, 8'h3C, cv);
        bus_read(8'h09, 8'h3C, "moto_a9", 8'h00);
        MODE = 1'b1; moto = 1'b0; RD = 1'b1; nclk(4);
`endif

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_left: observed %0d entries expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
